ram_ctrl: RTL
=============

Name: ram_ctrl

Overview:
- Parametrised single-port memory with a req/ready/done handshake, byte-lane write enables, programmable read latency and an optional zero-fill sweep after reset.
- Next-generation main memory behind the MAR/MDR on the bus datapath.
- Replaces a plain synchronous read/write array, so the control unit can sequence variable-latency memory cycles instead of fixed ones.

Parameters:
- BITS, 32, data word width; must be a multiple of 8.
- ADDR, 9, address width.
- RAMSIZE, 512, number of words; 1 <= RAMSIZE <= 2^ADDR.
- READ_LAT, 1, cycles from read accept to data valid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1, memory is zero-filled after reset before ready is asserted.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clr  input  1  reset; asynchronous, active-high.
- req  input  1  request strobe; sampled only when ready=1.
- write  input  1  request type; 1 = write, 0 = read; qualified by req.
- address  input  ADDR  word address.
- dataIn  input  BITS  write data.
- byteEn  input  BITS/8  write lane enables; bit i covers dataIn[8i+7:8i].
- ready  output  1  controller can accept a request this cycle.
- dataOut  output  BITS  read data; holds its value between reads.
- done  output  1  one-cycle completion pulse for the accepted request.
- err  output  1  one-cycle pulse with done when the request address is >= RAMSIZE.

Behaviour:
- States:
  - INIT: zero-fill sweep.
  - IDLE: waiting for a request.
  - RDWAIT: read latency countdown.
  - ready = (state == IDLE).
- Reset:
  - While clr=1: dataOut=0, done=0, err=0, sweep pointer=0, latency counter=0.
  - State is INIT if CLEAR_ON_RESET=1, otherwise IDLE.
  - Requests are ignored while clr=1.
  - clr asserted mid-sweep or mid-read aborts the operation immediately; no done is produced.
  - A sweep restarts from address 0.
- INIT:
  - One word per cycle, addresses 0..RAMSIZE-1, each written to 0.
  - Moves to IDLE on the edge that writes RAMSIZE-1.
  - ready=0 for exactly RAMSIZE cycles after clr falls.
- Accept rule: a request is accepted at posedge k iff ready=1 and req=1 at that edge. A req while ready=0 is dropped, not queued.
- Write accept (IDLE, write=1):
  - At edge k, RAM[address] byte lane i takes dataIn lane i iff byteEn[i]=1; other lanes are unchanged.
  - byteEn = 0 is legal: no change, still completes.
  - done=1 for the cycle following edge k. State stays IDLE and ready stays 1, so back-to-back writes run at one per cycle.
- Read accept (IDLE, write=0):
  - State goes to RDWAIT and the latency counter loads READ_LAT-1; address is latched at edge k.
  - Each edge in RDWAIT decrements the counter.
  - At edge k+READ_LAT: dataOut = RAM[latched address], done=1 for one cycle, state returns to IDLE.
  - ready=0 for cycles k..k+READ_LAT-1 (after edge k). byteEn is ignored.
- Read-after-write: a read accepted on the cycle after a write to the same address returns the newly written data, with lanes merged per byteEn.
- Out of range (address >= RAMSIZE):
  - Write: memory unchanged.
  - Read: dataOut loads 0.
  - Timing and done are identical to an in-range request; err=1 in the same cycle as done.
- done and err are registered outputs; they are 0 in every cycle not listed above.
- dataOut changes only on read completion or reset.

Test Plan:
- Reset sweep, CLEAR_ON_RESET=1, RAMSIZE=16: pulse clr -> ready=0 for 16 cycles then 1; a read of every address returns 0.
- Write 0xDEADBEEF to addr 5 with byteEn=4'b1111, then read addr 5 with READ_LAT=3 -> ready low 3 cycles; dataOut=0xDEADBEEF with done=1 exactly 3 edges after accept; err=0.
- Write 0x11223344 to addr 7 with byteEn=1111, then write 0xAABBCCDD to addr 7 with byteEn=0101, then read -> dataOut=0x11BB33DD.
- Back-to-back writes to addr 0,1,2 on consecutive cycles -> ready held 1 and three done pulses. Then req with write=0 while ready=0 during the read -> request dropped; only one done for the read.
- RAMSIZE=12, ADDR=4: read addr 13 -> dataOut=0, done=1 and err=1 in the same cycle. Write addr 13 -> err=1 and no array word changes.
- Assert clr at READ_LAT=4, two cycles into a read -> no done. After reset, dataOut=0 and the sweep restarts at address 0.

Source files
------------

// File: rtl/ram_ctrl_if.sv
// Request/response bundle between the control unit (master) and the memory controller (slave).
// One request per accept, completion reported by a single-cycle done/err pulse.
interface ram_ctrl_if #(
  parameter int BITS = 32,
  parameter int ADDR = 9
);
  logic              req;
  logic              write;
  logic [ADDR-1:0]   address;
  logic [BITS-1:0]   dataIn;
  logic [BITS/8-1:0] byteEn;
  logic              ready;
  logic [BITS-1:0]   dataOut;
  logic              done;
  logic              err;

  modport master (
    output req, write, address, dataIn, byteEn,
    input  ready, dataOut, done, err
  );

  modport slave (
    input  req, write, address, dataIn, byteEn,
    output ready, dataOut, done, err
  );
endinterface

// File: rtl/ram_ctrl.sv
// Single-port word memory with req/ready/done handshake, byte-lane writes,
// programmable read latency and an optional zero-fill sweep after reset.
module ram_ctrl #(
  parameter int BITS           = 32,
  parameter int ADDR           = 9,
  parameter int RAMSIZE        = 512,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic       clk,
  input logic       clr,
  ram_ctrl_if.slave bus
);
  localparam int              LANES     = BITS / 8;
  localparam logic [ADDR:0]   RAM_LIMIT = (ADDR + 1)'(RAMSIZE);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(RAMSIZE - 1);
  localparam logic [1:0]      LAT_LOAD  = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {INIT, IDLE, RDWAIT} state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] sweep_q, sweep_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_ok_q, rd_ok_d;
  logic [BITS-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            in_range;
  logic            accept;
  logic            wr_acc;
  logic            rd_acc;
  logic            rd_last;
  logic            sweep_en;
  logic            user_wr_en;
  logic            ram_rd_en;
  logic [ADDR-1:0] ram_waddr;
  logic [BITS-1:0] ram_rdata;

  assign in_range   = ({1'b0, bus.address} < RAM_LIMIT);
  assign accept     = (state_q == IDLE) && bus.req;
  assign wr_acc     = accept && bus.write;
  assign rd_acc     = accept && !bus.write;
  assign rd_last    = (state_q == RDWAIT) && (cnt_q == 2'd0);
  // Memory writes are gated by clr so nothing lands in the array during reset.
  assign sweep_en   = (state_q == INIT) && !clr;
  assign user_wr_en = wr_acc && in_range && !clr;
  assign ram_rd_en  = rd_acc && in_range && !clr;
  assign ram_waddr  = sweep_en ? sweep_q : bus.address;

  // One narrow array per byte lane; the read word is captured at accept and
  // stays stable through RDWAIT because no write can be accepted meanwhile.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem_lane [RAMSIZE];
      logic [7:0] lane_rdata;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = sweep_en || (user_wr_en && bus.byteEn[gi]);
      assign lane_wdata = sweep_en ? 8'h00 : bus.dataIn[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem_lane[ram_waddr] <= lane_wdata;
        end
        if (ram_rd_en) begin
          lane_rdata <= mem_lane[bus.address];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_rdata;
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= INIT;
      end else begin
        state_q <= IDLE;
      end
      sweep_q <= '0;
      cnt_q   <= '0;
      rd_ok_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      rd_ok_q <= rd_ok_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    rd_ok_d = rd_ok_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rd_acc) begin
          state_d = RDWAIT;
          cnt_d   = LAT_LOAD;
          rd_ok_d = in_range;
        end
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = wr_acc || rd_last;
    err_d  = (wr_acc && !in_range) || (rd_last && !rd_ok_q);
    dout_d = dout_q;
    if (rd_last) begin
      dout_d = rd_ok_q ? ram_rdata : '0;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.dataOut = dout_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule
